// File: rtl/vanilla_sb_stall_profiler.sv
// vanilla_sb_stall_profiler: attributes dependency-stall cycles to scoreboard causes
// and streams snapshot-and-cleared saturating counters over a valid/ready port.
package vanilla_sb_profiler_pkg;
  localparam int RV32_reg_els_gp = 32;
  localparam int RV32_reg_addr_width_gp = 5;
  typedef struct packed {
    logic idiv;
    logic remote_dram_load;
    logic remote_dram_amo;
    logic remote_dmem_overflow_load;
    logic remote_global_load;
    logic remote_group_load;
    logic remote_group_amo;
  } vanilla_isb_info_s;
  typedef struct packed {
    logic fdiv_fsqrt;
    logic remote_dram_load;
    logic remote_global_load;
    logic remote_group_load;
    logic remote_dmem_overflow_load;
  } vanilla_fsb_info_s;
endpackage

module vanilla_sb_stall_profiler
  import vanilla_sb_profiler_pkg::*;
#(
  parameter int counter_width_p = 32,
  parameter int reg_addr_width_lp = RV32_reg_addr_width_gp
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         stall_all_i,
  input  logic                         flush_i,
  input  logic                         stall_depend_i,
  input  vanilla_isb_info_s            int_sb_i [RV32_reg_els_gp],
  input  vanilla_fsb_info_s            float_sb_i [RV32_reg_els_gp],
  input  logic [reg_addr_width_lp-1:0] id_rs1_i,
  input  logic [reg_addr_width_lp-1:0] id_rs2_i,
  input  logic [reg_addr_width_lp-1:0] id_rs3_i,
  input  logic [reg_addr_width_lp-1:0] id_rd_i,
  input  logic                         id_read_rs1_i,
  input  logic                         id_read_rs2_i,
  input  logic                         id_write_rd_i,
  input  logic                         id_read_frs1_i,
  input  logic                         id_read_frs2_i,
  input  logic                         id_read_frs3_i,
  input  logic                         id_write_frd_i,
  input  logic                         dump_i,
  output logic                         dump_busy_o,
  output logic                         data_v_o,
  output logic [counter_width_p-1:0]   data_o,
  output logic [3:0]                   data_idx_o,
  output logic                         last_o,
  input  logic                         yumi_i
);
  typedef enum logic {IDLE, DUMP} state_e;
  state_e state, state_n;
  logic [3:0] idx;
  logic [3:0] ihit, fhit;
  logic [7:0] hit;
  logic [9:0] inc;
  logic count_en, take;
  logic [counter_width_p-1:0] cnt [10];
  logic [counter_width_p-1:0] snap [10];
  function automatic logic [3:0] int_cat(input vanilla_isb_info_s s);
    return {s.remote_group_load | s.remote_group_amo, s.remote_global_load,
            s.remote_dram_load | s.remote_dram_amo | s.remote_dmem_overflow_load, s.idiv};
  endfunction
  function automatic logic [3:0] flt_cat(input vanilla_fsb_info_s s);
    return {s.remote_group_load, s.remote_global_load,
            s.remote_dram_load | s.remote_dmem_overflow_load, s.fdiv_fsqrt};
  endfunction
  // x0 never carries a hazard; f0 is a real register
  assign ihit = ({4{id_read_rs1_i && |id_rs1_i}} & int_cat(int_sb_i[id_rs1_i]))
              | ({4{id_read_rs2_i && |id_rs2_i}} & int_cat(int_sb_i[id_rs2_i]))
              | ({4{id_write_rd_i && |id_rd_i}} & int_cat(int_sb_i[id_rd_i]));
  assign fhit = ({4{id_read_frs1_i}} & flt_cat(float_sb_i[id_rs1_i]))
              | ({4{id_read_frs2_i}} & flt_cat(float_sb_i[id_rs2_i]))
              | ({4{id_read_frs3_i}} & flt_cat(float_sb_i[id_rs3_i]))
              | ({4{id_write_frd_i}} & flt_cat(float_sb_i[id_rd_i]));
  assign hit = {fhit, ihit};
  assign count_en = stall_depend_i & ~stall_all_i & ~flush_i;
  assign inc = count_en ? {~|hit, 1'b1, hit} : '0;
  assign take = (state == IDLE) && dump_i;
  // on a snapshot edge the live counter restarts from this cycle's increment
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 10; i++) begin
        cnt[i] <= '0;
        snap[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 10; i++) begin
        cnt[i] <= take ? counter_width_p'(inc[i])
                : (inc[i] && ~&cnt[i]) ? cnt[i] + 1'b1 : cnt[i];
        if (take) snap[i] <= cnt[i];
      end
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE) ? (dump_i ? DUMP : IDLE)
            : ((yumi_i && idx == 4'd9) ? IDLE : DUMP);
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) idx <= '0;
    else if (state == DUMP && yumi_i) idx <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
  end
  always_comb begin
    dump_busy_o = (state == DUMP);
    data_v_o = (state == DUMP);
    data_o = data_v_o ? snap[idx] : '0;
    data_idx_o = idx;
    last_o = data_v_o && (idx == 4'd9);
  end
endmodule
